debounce_scheduler: RTL and testbench
=====================================

Name: debounce_scheduler

Overview:
- Shares one debounce timer among N_INPUTS raw switch/button pins. A round-robin arbiter grants the timer to one input at a time; nothing else is replicated per pin.
- Each input gets a 2-flop synchronizer and one bit of debounced state.
- Confirmed transitions are reported as press/release events on a valid/ready interface.
- Sits between board pins and the control FSMs. It replaces per-pin debouncer instances when pin count is high.

Parameters:
- N_INPUTS, 4, number of raw inputs; legal range 2..16.
- DEBOUNCE_CYCLES, 100000, consecutive cycles a changed level must hold before it is accepted; must be >= 2.

Ports:
- clk  input  1  system clock; all logic rising-edge.
- reset  input  1  synchronous, active-high reset.
- raw_inputs  input  N_INPUTS  asynchronous pin levels.
- stable_state  output  N_INPUTS  debounced level per input.
- timing_active  output  1  high while the shared timer is granted (state TIMING).
- event_valid  output  1  event pending.
- event_ready  input  1  consumer accepts event.
- event_index  output  $clog2(N_INPUTS)  input that changed.
- event_pressed  output  1  1 = new stable level is 1; 0 = new stable level is 0.

Behaviour:
- **Reset** (sync, takes priority over everything, including mid-TIMING and mid-REPORT):
  - sync flops = 0, stable_state = 0, rr_ptr = 0, counter = 0, state = IDLE.
  - event_valid = 0, event_index = 0, event_pressed = 0, timing_active = 0.
  - A pending event is discarded.
- **Synchronizer:** sync1 <= raw_inputs; sync2 <= sync1. mismatch[i] = sync2[i] != stable_state[i].
- **FSM states:** IDLE, TIMING, REPORT.
- **IDLE:**
  - If any mismatch bit is set, grant = first index found searching rr_ptr, rr_ptr+1, ... mod N_INPUTS.
  - Latch grant into cur_idx, clear counter, go to TIMING.
  - If no mismatch bit is set, stay in IDLE.
- **TIMING:**
  - If mismatch[cur_idx] = 0 (bounce back to stable level): abort, rr_ptr <= cur_idx+1 mod N, go to IDLE. No event; stable_state unchanged.
  - Else if counter == DEBOUNCE_CYCLES-1:
    - stable_state[cur_idx] <= sync2[cur_idx].
    - event_index <= cur_idx; event_pressed <= sync2[cur_idx]; event_valid <= 1.
    - Go to REPORT.
  - Else counter <= counter+1.
  - Mismatches on other inputs are ignored while TIMING; they wait for arbitration.
- **REPORT:**
  - event_valid held high; event_index and event_pressed held stable until accepted.
  - On event_valid && event_ready: event_valid <= 0, rr_ptr <= cur_idx+1 mod N, go to IDLE.
  - No arbitration during REPORT. The timer is stalled by backpressure.
- **Latency:**
  - Raw level first sampled at edge E0 and held clean: event_valid rises at edge E0+DEBOUNCE_CYCLES+2.
  - This assumes the FSM is in IDLE and the input wins arbitration.
  - Minimum gap between back-to-back events is DEBOUNCE_CYCLES+2 cycles with event_ready tied high.
- **Fairness:**
  - rr_ptr advances past the serviced or aborted index.
  - Every persistently mismatching input is granted within N_INPUTS grants.
- **Counter:** width $clog2(DEBOUNCE_CYCLES); it never wraps because it is compared against DEBOUNCE_CYCLES-1.
- **Simultaneous inputs:** no two events in the same cycle. Inputs changing together are reported in round-robin order starting at rr_ptr.
- **Level flips back before its grant:** no event. The mismatch disappears before arbitration.
- **event_ready while event_valid = 0:** ignored.

Test Plan:
- **Single clean press.** DEBOUNCE_CYCLES=4, N=4, reset 2 cycles, then raw_inputs[1] 0->1 held. Required: event_valid rises exactly 6 edges after first sample with event_index=1, event_pressed=1; stable_state=4'b0010; release later gives event_pressed=0.
- **Bounce rejection.** raw_inputs[2] high 3 cycles, low, repeated 5 times, then held high. Required: no event during bouncing; exactly one event, index 2, pressed=1, after the final hold; timing_active toggles on each abort.
- **Simultaneous press.** raw_inputs 4'b1011 at once, rr_ptr=0, event_ready=1. Required: events in index order 0, 1, 3, each DEBOUNCE_CYCLES+2 cycles apart; final stable_state=4'b1011.
- **Backpressure.** event_ready=0 for 20 cycles after event_valid. Required: event_valid, event_index, event_pressed held constant; a second pending input is not timed (timing_active=0) until acceptance.
- **Round-robin fairness.** Input 0 toggles continuously with a clean hold each time while input 3 is held changed. Required: input 3 reported no later than the second grant after its mismatch appears.
- **Reset mid-operation.** Assert reset during TIMING and again during REPORT. Required: next cycle all outputs 0, state IDLE; held raw level is then re-debounced and reported afresh.

Source files
------------

// File: rtl/debounce_scheduler.sv
// Round-robin shared debounce timer over N raw pins; press/release events on valid/ready.
// Event rises DEBOUNCE_CYCLES+2 edges after a clean level is first sampled; backpressure stalls the timer.
module debounce_scheduler #(
  parameter int N_INPUTS        = 4,
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_INPUTS-1:0]         raw_inputs,
  output logic [N_INPUTS-1:0]         stable_state,
  output logic                        timing_active,
  output logic                        event_valid,
  input  logic                        event_ready,
  output logic [$clog2(N_INPUTS)-1:0] event_index,
  output logic                        event_pressed
);

  localparam int IW = $clog2(N_INPUTS);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_TIMING, S_REPORT} state_t;

  state_t              r_state, w_state_nxt;
  logic [N_INPUTS-1:0] r_sync1, r_sync2;
  logic [N_INPUTS-1:0] r_stable, w_stable_nxt;
  logic [IW-1:0]       r_rr_ptr, w_rr_nxt;
  logic [IW-1:0]       r_cur_idx, w_cur_nxt;
  logic [CW-1:0]       r_cnt, w_cnt_nxt;
  logic                r_evt_vld, w_vld_nxt;
  logic [IW-1:0]       r_evt_idx, w_idx_nxt;
  logic                r_evt_pressed, w_pressed_nxt;
  logic [N_INPUTS-1:0] w_mismatch;
  logic [IW:0]         w_pick;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
    if (int'(v) == N_INPUTS - 1) return '0;
    return v + 1'b1;
  endfunction

  // Returns {found, index}; the lowest offset from ptr wins, so scan offsets downwards.
  function automatic logic [IW:0] rr_pick(input logic [N_INPUTS-1:0] req,
                                          input logic [IW-1:0]       ptr);
    logic [IW:0] res;
    int          s;
    res = '0;
    for (int k = N_INPUTS - 1; k >= 0; k--) begin
      s = int'(ptr) + k;
      if (s >= N_INPUTS) s = s - N_INPUTS;
      if (req[IW'(s)]) res = {1'b1, IW'(s)};
    end
    return res;
  endfunction

  assign w_mismatch = r_sync2 ^ r_stable;
  assign w_pick     = rr_pick(w_mismatch, r_rr_ptr);

  always_comb begin
    w_state_nxt   = r_state;
    w_stable_nxt  = r_stable;
    w_rr_nxt      = r_rr_ptr;
    w_cur_nxt     = r_cur_idx;
    w_cnt_nxt     = r_cnt;
    w_vld_nxt     = r_evt_vld;
    w_idx_nxt     = r_evt_idx;
    w_pressed_nxt = r_evt_pressed;
    case (r_state)
      S_IDLE: begin
        if (w_pick[IW]) begin
          w_cur_nxt   = w_pick[IW-1:0];
          w_cnt_nxt   = '0;
          w_state_nxt = S_TIMING;
        end
      end
      S_TIMING: begin
        if (!w_mismatch[r_cur_idx]) begin
          // Bounced back to the stable level: give the timer to the next pin.
          w_rr_nxt    = wrap_inc(r_cur_idx);
          w_state_nxt = S_IDLE;
        end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          w_stable_nxt[r_cur_idx] = r_sync2[r_cur_idx];
          w_idx_nxt               = r_cur_idx;
          w_pressed_nxt           = r_sync2[r_cur_idx];
          w_vld_nxt               = 1'b1;
          w_state_nxt             = S_REPORT;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_REPORT: begin
        if (event_ready) begin
          w_vld_nxt   = 1'b0;
          w_rr_nxt    = wrap_inc(r_cur_idx);
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_sync1       <= '0;
      r_sync2       <= '0;
      r_stable      <= '0;
      r_rr_ptr      <= '0;
      r_cur_idx     <= '0;
      r_cnt         <= '0;
      r_evt_vld     <= 1'b0;
      r_evt_idx     <= '0;
      r_evt_pressed <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_sync1       <= raw_inputs;
      r_sync2       <= r_sync1;
      r_stable      <= w_stable_nxt;
      r_rr_ptr      <= w_rr_nxt;
      r_cur_idx     <= w_cur_nxt;
      r_cnt         <= w_cnt_nxt;
      r_evt_vld     <= w_vld_nxt;
      r_evt_idx     <= w_idx_nxt;
      r_evt_pressed <= w_pressed_nxt;
    end
  end

  assign stable_state  = r_stable;
  assign timing_active = (r_state == S_TIMING);
  assign event_valid   = r_evt_vld;
  assign event_index   = r_evt_idx;
  assign event_pressed = r_evt_pressed;

endmodule

// File: tb/tb_debounce_scheduler.sv
// Scoreboard bench for debounce_scheduler: stimulus pushes expected events, a negedge monitor pops on handshake.
module tb_debounce_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] raw_inputs;
  logic [3:0] stable_state;
  logic       timing_active;
  logic       event_valid;
  logic       event_ready;
  logic [1:0] event_index;
  logic       event_pressed;

  typedef struct packed {
    logic [1:0] idx;
    logic       pressed;
  } exp_t;

  exp_t sb_q[$];
  int   hs_times[$];
  int   cyc      = 0;
  int   total    = 0;
  int   bad      = 0;
  int   rise_cnt = 0;
  logic prev_ta  = 1'b0;

  debounce_scheduler #(.N_INPUTS(4), .DEBOUNCE_CYCLES(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .raw_inputs    (raw_inputs),
    .stable_state  (stable_state),
    .timing_active (timing_active),
    .event_valid   (event_valid),
    .event_ready   (event_ready),
    .event_index   (event_index),
    .event_pressed (event_pressed)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [1:0] idx, input logic pressed);
    exp_t e;
    e.idx     = idx;
    e.pressed = pressed;
    sb_q.push_back(e);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!event_valid && n < 100) begin
      step(1);
      n++;
    end
    chk({name, "_valid_seen"}, int'(event_valid), 1);
  endtask

  task automatic wait_events(input string name);
    int n = 0;
    while (sb_q.size() != 0 && n < 300) begin
      step(1);
      n++;
    end
    chk({name, "_drained"}, sb_q.size(), 0);
    step(3);
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_stable"}, int'(stable_state), 0);
    chk({name, "_timing"}, int'(timing_active), 0);
    chk({name, "_valid"}, int'(event_valid), 0);
    chk({name, "_index"}, int'(event_index), 0);
    chk({name, "_pressed"}, int'(event_pressed), 0);
  endtask

  // Monitor: compares every accepted event against the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (timing_active && !prev_ta) rise_cnt++;
        if (event_valid && event_ready) begin
          hs_times.push_back(cyc);
          if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious_event: got index=%0d pressed=%0d expected no event (cycle %0d)",
                     event_index, event_pressed, cyc);
          end else begin
            e = sb_q.pop_front();
            chk("event_index", int'(event_index), int'(e.idx));
            chk("event_pressed", int'(event_pressed), int'(e.pressed));
          end
        end
      end
      prev_ta = timing_active;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int t_set;
    reset       = 1'b1;
    raw_inputs  = 4'b0000;
    event_ready = 1'b1;
    step(2);
    chk_zero("reset");
    reset = 1'b0;
    step(2);

    // Single clean press then release of input 1.
    push(2'd1, 1'b1);
    raw_inputs = 4'b0010;
    t_set = cyc;
    wait_valid("press1");
    chk("press1_latency", cyc - t_set, 7);
    chk("press1_stable", int'(stable_state), 4'b0010);
    wait_events("press1");
    push(2'd1, 1'b0);
    raw_inputs = 4'b0000;
    wait_events("release1");
    chk("release1_stable", int'(stable_state), 0);

    // Bounce rejection on input 2: five 3-cycle pulses, then a clean hold.
    rise_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      raw_inputs[2] = 1'b1;
      step(3);
      raw_inputs[2] = 1'b0;
      step(3);
    end
    chk("bounce_no_valid", int'(event_valid), 0);
    chk("bounce_stable", int'(stable_state), 0);
    push(2'd2, 1'b1);
    raw_inputs[2] = 1'b1;
    wait_events("bounce");
    chk("bounce_timing_rises", rise_cnt, 6);
    chk("bounce_final_stable", int'(stable_state), 4'b0100);

    // Simultaneous press of inputs 0,1,3 from rr_ptr = 0.
    raw_inputs = 4'b0000;
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(3);
    hs_times.delete();
    push(2'd0, 1'b1);
    push(2'd1, 1'b1);
    push(2'd3, 1'b1);
    raw_inputs = 4'b1011;
    wait_events("simul");
    chk("simul_count", hs_times.size(), 3);
    if (hs_times.size() == 3) begin
      chk("simul_gap01", hs_times[1] - hs_times[0], 6);
      chk("simul_gap13", hs_times[2] - hs_times[1], 6);
    end
    chk("simul_stable", int'(stable_state), 4'b1011);

    // Backpressure: release 0 and press 2 together, hold ready low 20 cycles.
    event_ready = 1'b0;
    push(2'd0, 1'b0);
    push(2'd2, 1'b1);
    raw_inputs = 4'b1110;
    wait_valid("bp");
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("bp_valid_held", int'(event_valid), 1);
      chk("bp_index_held", int'(event_index), 0);
      chk("bp_pressed_held", int'(event_pressed), 0);
      chk("bp_timer_stalled", int'(timing_active), 0);
    end
    event_ready = 1'b1;
    wait_events("bp");
    chk("bp_stable", int'(stable_state), 4'b1110);

    // Fairness: input 0 re-toggles while input 3 waits; 3 must be served before 0 again.
    push(2'd0, 1'b1);
    push(2'd3, 1'b0);
    push(2'd0, 1'b0);
    raw_inputs = 4'b1111;
    step(3);
    raw_inputs = 4'b0111;
    wait_valid("rr");
    event_ready = 1'b0;
    raw_inputs  = 4'b0110;
    step(4);
    event_ready = 1'b1;
    wait_events("rr");
    chk("rr_stable", int'(stable_state), 4'b0110);

    // Reset during TIMING, then during REPORT; held levels are re-debounced.
    raw_inputs = 4'b0111;
    step(4);
    chk("mid_timing_active", int'(timing_active), 1);
    reset = 1'b1;
    step(1);
    chk_zero("rst_timing");
    reset = 1'b0;
    event_ready = 1'b0;
    wait_valid("pre_rst_report");
    chk("pre_rst_index", int'(event_index), 0);
    chk("pre_rst_pressed", int'(event_pressed), 1);
    reset = 1'b1;
    step(1);
    chk_zero("rst_report");
    reset = 1'b0;
    event_ready = 1'b1;
    push(2'd0, 1'b1);
    push(2'd1, 1'b1);
    push(2'd2, 1'b1);
    wait_events("post_rst");
    chk("post_rst_stable", int'(stable_state), 4'b0111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
